ahbl_mem_responder: RTL
=======================

AHBL_MEM_RESPONDER -- requirements
Module: ahbl_mem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024, memory depth in 32-bit words, power of two, 16..65536.
REQ-002 Parameter WAIT_STATES, default 0, data-phase wait cycles per OKAY transfer, 0..7.
REQ-003 HCLK  input  1  sole clock, all state on rising edge.
REQ-004 HRESETn  input  1  reset, asynchronous assert, active-low.
REQ-005 HSEL  input  1  slave select from bus decoder.
REQ-006 HADDR  input  32  byte address; bits [27:0] form the offset within the 256MB page.
REQ-007 HTRANS  input  2  transfer type: IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
REQ-008 HSIZE  input  3  transfer size: 0=byte, 1=halfword, 2=word.
REQ-009 HWRITE  input  1  1=write, 0=read.
REQ-010 HWDATA  input  32  write data, valid in the data phase.
REQ-011 HREADY  input  1  bus-level ready, muxed by the splitter.
REQ-012 HREADYOUT  output  1  this slave's ready.
REQ-013 HRDATA  output  32  read data.
REQ-014 HRESP  output  1  0=OKAY, 1=ERROR.

Function
REQ-015 Address phase is accepted only when HSEL & HTRANS[1] & HREADY; the block then registers HADDR, HSIZE and HWRITE.
REQ-016 IDLE/BUSY transfers and unselected cycles produce no data phase; the next cycle shows HREADYOUT=1, HRESP=0.
REQ-017 FSM states: IDLE, WAIT, ERR1, ERR2.
REQ-018 IDLE->WAIT on an accepted OKAY transfer when WAIT_STATES>0; IDLE->ERR1 on an accepted erroring transfer (see REQ-029); otherwise stay in IDLE.
REQ-019 WAIT: HREADYOUT=0 for exactly WAIT_STATES cycles via a down-counter; on the cycle the count is exhausted, HREADYOUT=1 and the FSM returns to IDLE.
REQ-020 WAIT_STATES=0: the data phase completes in the cycle right after the address phase, with HREADYOUT=1.
REQ-021 A new address phase accepted on the final data-phase cycle is processed back-to-back, with no idle bubble.
REQ-022 Writes: HWDATA is sampled on the final data-phase cycle and committed at that edge.
REQ-023 Write byte enables: byte -> lane HADDR[1:0]; halfword -> lanes {HADDR[1],0} and {HADDR[1],1}; word -> all four lanes.
REQ-024 Reads return the full 32-bit word at HADDR[N+1:2], N=log2(DEPTH_WORDS); the master selects the lanes.
REQ-025 HRDATA is valid only when HREADYOUT=1 during a read data phase; at all other times it is 32'h0.
REQ-026 Read-after-write forwarding: if a read address phase overlaps the final data phase of a write to the same word, HRDATA returns the merged new data (written lanes new, other lanes old).

Reset
REQ-027 While HRESETn=0: FSM=IDLE, counter=0, HREADYOUT=1, HRESP=0, HRDATA=0, captured address/control cleared; memory contents are not reset.
REQ-028 Reset asserted mid-data-phase abandons the transfer; no memory write occurs.

Configuration
REQ-029 With AHBL_MEM_ERR_EN defined, an accepted transfer errors if any of these hold:
  - offset >= DEPTH_WORDS*4
  - HSIZE>2
  - halfword access with HADDR[0]=1
  - word access with HADDR[1:0]!=0
REQ-030 Error response (AHBL_MEM_ERR_EN defined): ERR1 drives HREADYOUT=0, HRESP=1; ERR2 drives HREADYOUT=1, HRESP=1; then the FSM returns to IDLE; no wait states are inserted and no memory write occurs.
REQ-031 Without AHBL_MEM_ERR_EN: HRESP is tied to 0, ERR1/ERR2 are unreachable, the offset wraps modulo DEPTH_WORDS*4, misaligned low address bits are ignored per REQ-023, and HSIZE>2 is treated as word.

Structure
REQ-032 Shared package ahbl_pkg holds the HTRANS, HSIZE and HRESP encodings and the FSM state typedef.
REQ-033 Storage is the sub-module ahbl_mem_array: synchronous read, synchronous write with 4-bit byte enables, one port each.

Verification
REQ-034 WAIT_STATES=0: write word 32'hDEADBEEF to 0x0000_0010, then read 0x0000_0010 back-to-back -> read data phase HREADYOUT=1 with HRDATA=32'hDEADBEEF (forwarded).
REQ-035 WAIT_STATES=3: read of 0x0000_0000 -> HREADYOUT low exactly 3 cycles, then high with the stored word and HRESP=0.
REQ-036 Byte write 8'hA5 to 0x0000_0022 over a word of 32'h11223344 at 0x20 -> a later word read returns 32'h11A53344.
REQ-037 AHBL_MEM_ERR_EN, DEPTH_WORDS=1024: read of 0x0000_1000 -> ERR1 (HREADYOUT=0, HRESP=1) then ERR2 (HREADYOUT=1, HRESP=1); halfword write to 0x3 -> same response, memory unchanged.
REQ-038 HRESETn pulsed low during WAIT of a write to 0x40 -> outputs return to reset values immediately, and 0x40 holds its old value.
REQ-039 HSEL=1 with HTRANS=BUSY, then HSEL=0 with HTRANS=NONSEQ -> no accesses occur, and HREADYOUT=1, HRESP=0 throughout.

Source files
------------

// File: rtl/ahbl_pkg.sv
// Shared AHB-Lite encodings and helpers for the memory responder.
// Holds the HTRANS/HSIZE/HRESP encodings, the responder FSM state type and
// the byte-lane helpers used by both the responder and its storage array.
package ahbl_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  localparam int unsigned BUS_BYTES = 4;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StErr1,
    StErr2
  } ahbl_state_e;

  // NONSEQ and SEQ carry a data phase; IDLE and BUSY do not.
  function automatic logic is_active_trans(logic [1:0] trans);
    logic active;
    unique case (trans)
      HTRANS_IDLE, HTRANS_BUSY: active = 1'b0;
      HTRANS_NONSEQ, HTRANS_SEQ: active = 1'b1;
      default: active = 1'b0;
    endcase
    return active;
  endfunction

  // Sizes above a word fall through to the full-word mask.
  function automatic logic [3:0] byte_enables(logic [2:0] size, logic [1:0] lo);
    logic [3:0] be;
    case (size)
      HSIZE_BYTE: be = 4'b0001 << lo;
      HSIZE_HALF: be = lo[1] ? 4'b1100 : 4'b0011;
      default:    be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] merge_lanes(logic [31:0] old_word, logic [31:0] new_word,
                                              logic [3:0] be);
    logic [31:0] merged;
    for (int i = 0; i < 4; i++) begin
      merged[8*i +: 8] = be[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/ahbl_mem_array.sv
// Word-wide storage for the AHB-Lite memory responder.
// One synchronous read port (data registered, held while rd_en is low) and
// one synchronous write port with per-byte enables. Contents are not reset.
// Ports:
//   clk      - clock
//   rd_en    - capture mem[rd_addr] into rd_data at the next edge
//   rd_addr  - word read address
//   rd_data  - registered read data
//   wr_en    - commit write at the next edge
//   wr_addr  - word write address
//   wr_be    - byte-lane enables
//   wr_data  - write data
module ahbl_mem_array
  import ahbl_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [31:0]   rd_data,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [3:0]    wr_be,
  input  logic [31:0]   wr_data
);

  logic [31:0] mem [DEPTH_WORDS];

  // A read and write to the same word on one edge returns the old contents.
  always_ff @(posedge clk) begin
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
    if (wr_en) begin
      for (int i = 0; i < BUS_BYTES; i++) begin
        if (wr_be[i]) begin
          mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/ahbl_mem_responder.sv
// AHB-Lite memory slave with configurable wait states.
// Build option: define AHBL_MEM_ERR_EN to enable ERROR responses for
// out-of-range, oversize and misaligned transfers; otherwise HRESP is tied
// OKAY, offsets wrap and misaligned low address bits are ignored.
// Ports:
//   HCLK, HRESETn          - clock, async active-low reset
//   HSEL, HADDR, HTRANS,
//   HSIZE, HWRITE, HWDATA  - AHB-Lite address/data phase inputs
//   HREADY                 - bus-level ready (from splitter mux)
//   HREADYOUT, HRDATA,
//   HRESP                  - slave response
module ahbl_mem_responder
  import ahbl_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic [2:0]  HSIZE,
  input  logic        HWRITE,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic        HREADYOUT,
  output logic [31:0] HRDATA,
  output logic        HRESP
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam logic [2:0]  WS = 3'(WAIT_STATES);

  ahbl_state_e   state_q, state_d;
  logic [2:0]    cnt_q, cnt_d;

  // Captured address phase
  logic [AW+1:0] addr_q;
  logic [2:0]    size_q;
  logic          write_q;
  logic          dvalid_q;   // an OKAY transfer is in its data phase

  // Read-after-write forwarding capture
  logic          fwd_hit_q;
  logic [3:0]    fwd_be_q;
  logic [31:0]   fwd_data_q;

  logic          accept;
  logic          req_err;
  logic          req_ok;
  logic          ready;
  logic          resp;
  logic          final_cycle;
  logic [3:0]    cur_be;
  logic          fwd_hit_d;
  logic [31:0]   mem_rdata;

  assign accept = HSEL & is_active_trans(HTRANS) & HREADY;
  assign req_ok = accept & ~req_err;

`ifdef AHBL_MEM_ERR_EN
  localparam logic [27:0] PAGE_BYTES = 28'(DEPTH_WORDS * 4);

  logic addr_err;
  logic size_err;
  logic align_err;
  logic unused_haddr;

  assign addr_err  = HADDR[27:0] >= PAGE_BYTES;
  assign size_err  = HSIZE > HSIZE_WORD;
  assign align_err = ((HSIZE == HSIZE_HALF) && HADDR[0]) ||
                     ((HSIZE == HSIZE_WORD) && (HADDR[1:0] != 2'b00));
  assign req_err   = accept & (addr_err | size_err | align_err);
  assign HRESP     = resp;
  assign unused_haddr = ^HADDR[31:28];
`else
  logic unused_sig;

  assign req_err    = 1'b0;
  assign HRESP      = HRESP_OKAY;
  assign unused_sig = ^{HADDR[31:AW+2], resp};
`endif

  // Output decode from state
  always_comb begin
    ready = 1'b1;
    resp  = HRESP_OKAY;
    unique case (state_q)
      StIdle: ready = 1'b1;
      StWait: ready = (cnt_q == 3'd0);
      StErr1: begin
        ready = 1'b0;
        resp  = HRESP_ERROR;
      end
      StErr2: begin
        ready = 1'b1;
        resp  = HRESP_ERROR;
      end
      default: ready = 1'b1;
    endcase
  end

  assign HREADYOUT   = ready;
  assign final_cycle = dvalid_q & ready;
  assign cur_be      = byte_enables(size_q, addr_q[1:0]);

  // Next-state: any ready cycle (IDLE, last WAIT cycle, ERR2) may take a new transfer.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == StErr1) begin
      state_d = StErr2;
    end else if (ready) begin
      if (req_err) begin
        state_d = StErr1;
      end else if (req_ok && (WS != 3'd0)) begin
        state_d = StWait;
        cnt_d   = WS;
      end else begin
        state_d = StIdle;
      end
    end else begin
      cnt_d = cnt_q - 3'd1;
    end
  end

  // A read accepted while a write to the same word finishes sees stale memory
  // at that edge; capture the write lanes so the read can merge them.
  assign fwd_hit_d = final_cycle & write_q & ~HWRITE &
                     (addr_q[AW+1:2] == HADDR[AW+1:2]);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= StIdle;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      addr_q     <= '0;
      size_q     <= 3'd0;
      write_q    <= 1'b0;
      dvalid_q   <= 1'b0;
      fwd_hit_q  <= 1'b0;
      fwd_be_q   <= 4'd0;
      fwd_data_q <= 32'd0;
    end else if (accept) begin
      addr_q     <= HADDR[AW+1:0];
      size_q     <= HSIZE;
      write_q    <= HWRITE;
      dvalid_q   <= ~req_err;
      fwd_hit_q  <= fwd_hit_d;
      fwd_be_q   <= cur_be;
      fwd_data_q <= HWDATA;
    end else if (ready) begin
      dvalid_q <= 1'b0;
    end
  end

  ahbl_mem_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (AW)
  ) u_mem (
    .clk    (HCLK),
    .rd_en  (req_ok & ~HWRITE),
    .rd_addr(HADDR[AW+1:2]),
    .rd_data(mem_rdata),
    .wr_en  (final_cycle & write_q),
    .wr_addr(addr_q[AW+1:2]),
    .wr_be  (cur_be),
    .wr_data(HWDATA)
  );

  always_comb begin
    HRDATA = 32'h0;
    if (final_cycle && !write_q) begin
      HRDATA = fwd_hit_q ? merge_lanes(mem_rdata, fwd_data_q, fwd_be_q) : mem_rdata;
    end
  end

endmodule
